ubtb_update_ctrl: RTL and testbench

UBTB_UPDATE_CTRL -- requirements
Module: ubtb_update_ctrl

---
 rtl/ubtb_update_ctrl.sv | 97 +++++++++
 tb/tb_ubtb_update_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ubtb_update_ctrl.sv
// uBTB update controller: queues resolved taken-branch corrections, drains them
// into the uBTB write port, and raises a one-cycle fetch redirect on mispredicts.
`ifndef MXLEN
`define MXLEN 32
`endif

module ubtb_update_ctrl #(
  parameter int XLEN   = `MXLEN,
  parameter int QDEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_res_vld,
  output logic            o_res_rdy,
  input  logic [XLEN-1:0] i_res_pc,
  input  logic [XLEN-1:0] i_res_target,
  input  logic            i_res_taken,
  input  logic            i_res_pred_hit,
  input  logic [XLEN-1:0] i_res_pred_target,
  input  logic            i_flush,
  input  logic            i_ubtb_hold,
  output logic            o_ubtb_update,
  output logic [XLEN-1:0] o_pc_jumpsrc,
  output logic [XLEN-1:0] o_pc_jumpdst,
  output logic            o_redirect_vld,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [15:0]     o_mispred_cnt
);

  localparam int AW = $clog2(QDEPTH);

  typedef struct packed {
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] dst;
  } ent_t;

  ent_t          q_mem [QDEPTH];
  logic [AW-1:0] wptr, rptr, yptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic          accept, need_upd, mispred, pop, coal, push;

  assign full  = (count == (AW+1)'(QDEPTH));
  assign empty = (count == '0);
  assign yptr  = wptr - AW'(1);

  assign o_res_rdy = !full;
  assign accept    = i_res_vld && o_res_rdy && !i_flush;
  assign need_upd  = i_res_taken && (!i_res_pred_hit || (i_res_pred_target != i_res_target));
  assign mispred   = (i_res_taken != i_res_pred_hit) || need_upd;

  assign pop           = !empty && !i_ubtb_hold;
  assign o_ubtb_update = pop;
  assign o_pc_jumpsrc  = empty ? '0 : q_mem[rptr].src;
  assign o_pc_jumpdst  = empty ? '0 : q_mem[rptr].dst;

  // Youngest entry can only be rewritten if it is not also the head leaving now.
  assign coal = accept && need_upd && !empty && (q_mem[yptr].src == i_res_pc)
             && !(pop && (count == (AW+1)'(1)));
  assign push = accept && need_upd && !coal;

  always_ff @(posedge i_clk) begin
    if (push) q_mem[wptr] <= '{src: i_res_pc, dst: i_res_target};
    if (coal) q_mem[yptr].dst <= i_res_target;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_redirect_vld <= 1'b0;
      o_redirect_pc  <= '0;
      o_mispred_cnt  <= '0;
    end else begin
      o_redirect_vld <= accept && mispred;
      if (accept && mispred) begin
        o_redirect_pc <= i_res_taken ? i_res_target : i_res_pc + XLEN'(4);
        if (o_mispred_cnt != 16'hFFFF) o_mispred_cnt <= o_mispred_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ubtb_update_ctrl.sv
// Bench for ubtb_update_ctrl: directed vector table, randomized run against a
// queue-based reference model, and a counter saturation sweep.
module tb_ubtb_update_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_res_vld, i_res_taken, i_res_pred_hit, i_flush, i_ubtb_hold;
  logic [31:0] i_res_pc, i_res_target, i_res_pred_target;
  logic        o_res_rdy, o_ubtb_update, o_redirect_vld;
  logic [31:0] o_pc_jumpsrc, o_pc_jumpdst, o_redirect_pc;
  logic [15:0] o_mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  ubtb_update_ctrl #(.XLEN(32), .QDEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_res_vld(i_res_vld), .o_res_rdy(o_res_rdy),
    .i_res_pc(i_res_pc), .i_res_target(i_res_target), .i_res_taken(i_res_taken),
    .i_res_pred_hit(i_res_pred_hit), .i_res_pred_target(i_res_pred_target),
    .i_flush(i_flush), .i_ubtb_hold(i_ubtb_hold), .o_ubtb_update(o_ubtb_update),
    .o_pc_jumpsrc(o_pc_jumpsrc), .o_pc_jumpdst(o_pc_jumpdst),
    .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
    .o_mispred_cnt(o_mispred_cnt)
  );

  typedef struct {
    logic        rst, vld, tk, hit, fl, hold;
    logic [31:0] pc, tgt, ptgt;
    logic        chk, e_rdy, e_upd, e_rvld;
    logic [31:0] e_src, e_dst, e_rpc;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] s, d;
  } ent_t;

  vec_t tv[$];
  ent_t mq[$];
  int   m_cnt;
  logic m_rvld;
  logic [31:0] m_rpc;

  task automatic add(input logic rst, vld, tk, hit, fl, hold,
                     input logic [31:0] pc, tgt, ptgt, input logic chk, e_rdy, e_upd,
                     input logic [31:0] e_src, e_dst, input logic e_rvld,
                     input logic [31:0] e_rpc, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.tk = tk; v.hit = hit; v.fl = fl; v.hold = hold;
    v.pc = pc; v.tgt = tgt; v.ptgt = ptgt; v.chk = chk; v.e_rdy = e_rdy;
    v.e_upd = e_upd; v.e_src = e_src; v.e_dst = e_dst; v.e_rvld = e_rvld;
    v.e_rpc = e_rpc; v.e_cnt = e_cnt;
    tv.push_back(v);
  endtask

  task automatic drive(input logic rst, vld, tk, hit, fl, hold,
                       input logic [31:0] pc, tgt, ptgt);
    i_rst = rst; i_res_vld = vld; i_res_taken = tk; i_res_pred_hit = hit;
    i_flush = fl; i_ubtb_hold = hold; i_res_pc = pc; i_res_target = tgt;
    i_res_pred_target = ptgt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Redirect PC is only defined while the pulse is up, or as its reset value of zero.
  task automatic chk_all(input string tag, input logic e_rdy, e_upd,
                         input logic [31:0] e_src, e_dst, input logic e_rvld,
                         input logic [31:0] e_rpc, input logic [15:0] e_cnt);
    chk({tag, ".rdy"},  {31'd0, o_res_rdy},      {31'd0, e_rdy});
    chk({tag, ".upd"},  {31'd0, o_ubtb_update},  {31'd0, e_upd});
    chk({tag, ".src"},  o_pc_jumpsrc,            e_src);
    chk({tag, ".dst"},  o_pc_jumpdst,            e_dst);
    chk({tag, ".rvld"}, {31'd0, o_redirect_vld}, {31'd0, e_rvld});
    chk({tag, ".cnt"},  {16'd0, o_mispred_cnt},  {16'd0, e_cnt});
    if (e_rvld || e_cnt == 16'd0) chk({tag, ".rpc"}, o_redirect_pc, e_rpc);
  endtask

  // Reference model: advance one clock edge given the inputs currently applied.
  task automatic model_step();
    logic acc, need, mis, pop, coal;
    if (i_rst) begin
      mq.delete(); m_cnt = 0; m_rvld = 1'b0; m_rpc = '0;
      return;
    end
    acc  = i_res_vld && (mq.size() < 4) && !i_flush;
    need = i_res_taken && (!i_res_pred_hit || i_res_pred_target != i_res_target);
    mis  = (i_res_taken != i_res_pred_hit) || need;
    pop  = (mq.size() > 0) && !i_ubtb_hold;
    m_rvld = acc && mis;
    if (acc && mis) begin
      m_rpc = i_res_taken ? i_res_target : i_res_pc + 32'd4;
      if (m_cnt < 65535) m_cnt++;
    end
    coal = acc && need && mq.size() > 0 && mq[$].s == i_res_pc && !(pop && mq.size() == 1);
    if (coal) mq[$].d = i_res_target;
    if (pop) void'(mq.pop_front());
    if (acc && need && !coal) mq.push_back('{s: i_res_pc, d: i_res_target});
  endtask

  initial begin
    logic e_rdy, e_upd;
    logic [31:0] e_src, e_dst, pc, tgt;
    logic rst, vld, tk, hit, fl, hold;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rst vld tk hit fl hold  pc          tgt      ptgt    chk rdy upd src     dst     rvld rpc     cnt
    add(1, 0, 0, 0, 0, 0, 0,           0,       0,      0,  0, 0, 0,      0,      0, 0,      0);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 1, 1, 0, 0, 0, 'h100,       'h200,   0,      1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'h100,  'h200,  1, 'h200,  1);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 'h200,  1);
    add(0, 1, 0, 1, 0, 0, 'h100,       0,       'h200,  1,  1, 0, 0,      0,      0, 'h200,  1);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      1, 'h104,  2);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 'h104,  2);
    add(0, 1, 1, 0, 0, 1, 'h10,        'h20,    0,      1,  1, 0, 0,      0,      0, 'h104,  2);
    add(0, 1, 1, 0, 0, 1, 'h14,        'h24,    0,      1,  1, 0, 'h10,   'h20,   1, 'h20,   3);
    add(0, 1, 1, 0, 0, 1, 'h18,        'h28,    0,      1,  1, 0, 'h10,   'h20,   1, 'h24,   4);
    add(0, 1, 1, 0, 0, 1, 'h1c,        'h2c,    0,      1,  1, 0, 'h10,   'h20,   1, 'h28,   5);
    add(0, 1, 1, 0, 0, 1, 'h30,        'h40,    0,      1,  0, 0, 'h10,   'h20,   1, 'h2c,   6);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  0, 1, 'h10,   'h20,   0, 'h2c,   6);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'h14,   'h24,   0, 'h2c,   6);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'h18,   'h28,   0, 'h2c,   6);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'h1c,   'h2c,   0, 'h2c,   6);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 'h2c,   6);
    add(0, 1, 1, 0, 0, 1, 'h100,       'h200,   0,      1,  1, 0, 0,      0,      0, 'h2c,   6);
    add(0, 1, 1, 0, 0, 1, 'h100,       'h300,   0,      1,  1, 0, 'h100,  'h200,  1, 'h200,  7);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'h100,  'h300,  1, 'h300,  8);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 'h300,  8);
    add(0, 1, 1, 0, 1, 0, 'h50,        'h60,    0,      1,  1, 0, 0,      0,      0, 'h300,  8);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 'h300,  8);
    add(0, 1, 1, 0, 0, 1, 'h70,        'h80,    0,      1,  1, 0, 0,      0,      0, 'h300,  8);
    add(0, 1, 1, 0, 0, 1, 'h74,        'h84,    0,      1,  1, 0, 'h70,   'h80,   1, 'h80,   9);
    add(0, 1, 1, 0, 0, 1, 'h78,        'h88,    0,      1,  1, 0, 'h70,   'h80,   1, 'h84,   10);
    add(1, 0, 0, 0, 0, 1, 0,           0,       0,      1,  1, 0, 'h70,   'h80,   1, 'h88,   11);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 1, 1, 1, 0, 0, 'h90,        'ha0,    'ha0,   1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 1, 1, 1, 0, 0, 'h90,        'ha0,    'hb0,   1,  1, 0, 0,      0,      0, 0,      0);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'h90,   'ha0,   1, 'ha0,   1);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      0, 'ha0,   1);
    add(0, 1, 1, 0, 0, 0, 'hc0,        'hd0,    0,      1,  1, 0, 0,      0,      0, 'ha0,   1);
    add(0, 1, 1, 0, 0, 0, 'hc0,        'he0,    0,      1,  1, 1, 'hc0,   'hd0,   1, 'hd0,   2);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 1, 'hc0,   'he0,   1, 'he0,   3);
    add(0, 1, 0, 1, 0, 0, 'hFFFFFFFC,  0,       'h10,   1,  1, 0, 0,      0,      0, 'he0,   3);
    add(0, 0, 0, 0, 0, 0, 0,           0,       0,      1,  1, 0, 0,      0,      1, 0,      4);

    foreach (tv[i]) begin
      @(negedge i_clk);
      drive(tv[i].rst, tv[i].vld, tv[i].tk, tv[i].hit, tv[i].fl, tv[i].hold,
            tv[i].pc, tv[i].tgt, tv[i].ptgt);
      #4;
      if (tv[i].chk)
        chk_all($sformatf("row%0d", i), tv[i].e_rdy, tv[i].e_upd, tv[i].e_src,
                tv[i].e_dst, tv[i].e_rvld, tv[i].e_rpc, tv[i].e_cnt);
    end

    // Randomized run; the leading reset aligns the model with the DUT.
    @(negedge i_clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_step();
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clk);
      rst  = ($urandom_range(0, 99) < 2);
      vld  = ($urandom_range(0, 99) < 70);
      tk   = $urandom_range(0, 1);
      hit  = $urandom_range(0, 1);
      fl   = ($urandom_range(0, 99) < 10);
      hold = ($urandom_range(0, 99) < 40);
      pc   = 32'h100 + 32'd4 * $urandom_range(0, 3);
      tgt  = 32'h1000 + 32'd4 * $urandom_range(0, 15);
      drive(rst, vld, tk, hit, fl, hold, pc, tgt,
            $urandom_range(0, 1) ? tgt : 32'h1000 + 32'd4 * $urandom_range(0, 15));
      #4;
      e_rdy = (mq.size() < 4);
      e_upd = (mq.size() > 0) && !hold;
      e_src = (mq.size() > 0) ? mq[0].s : 32'd0;
      e_dst = (mq.size() > 0) ? mq[0].d : 32'd0;
      chk_all($sformatf("rnd%0d", n), e_rdy, e_upd, e_src, e_dst, m_rvld, m_rpc, 16'(m_cnt));
      model_step();
    end

    // Saturation sweep: not-taken resolutions predicted taken always mispredict.
    @(negedge i_clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    drive(0, 1, 0, 1, 0, 0, 'h400, 0, 'h800);
    repeat (65534) @(negedge i_clk);
    #4 chk("sat_fffe", {16'd0, o_mispred_cnt}, 32'hFFFE);
    @(negedge i_clk);
    #4 chk("sat_ffff", {16'd0, o_mispred_cnt}, 32'hFFFF);
    repeat (5) @(negedge i_clk);
    #4 chk("sat_hold", {16'd0, o_mispred_cnt}, 32'hFFFF);
    chk("sat_noupd", {31'd0, o_ubtb_update}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
